// File: rtl/aq_mmu_jtlb_data_ctrl.sv
// JTLB data array access controller: arbitrates invalidate-all sweep, refill writes and lookup reads.
// Optional macro AQ_MMU_JTLB_DATA_OUT_FLOP_EN registers the array read data (read valid at N+2).
module aq_mmu_jtlb_data_ctrl #(
  parameter int IDX_W     = 6,
  parameter int ENTRY_NUM = 64,
  parameter int WAY_W     = 44
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  input  logic                 rd_req,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_gnt,
  input  logic                 wr_req,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [1:0]           wr_way,
  input  logic [WAY_W-1:0]     wr_data,
  output logic                 wr_gnt,
  input  logic                 inv_all_req,
  output logic                 inv_busy,
  output logic                 jtlb_data_cen,
  output logic [1:0]           jtlb_data_wen,
  output logic [8:0]           jtlb_data_idx,
  output logic [2*WAY_W-1:0]   jtlb_data_din,
  input  logic [2*WAY_W-1:0]   jtlb_data_dout,
  output logic                 rd_vld,
  output logic [WAY_W-1:0]     rd_data_way1,
  output logic [WAY_W-1:0]     rd_data_way0
);

  localparam logic [IDX_W-1:0] INV_LAST = IDX_W'(ENTRY_NUM - 1);

  typedef enum logic {
    IDLE = 1'b0,
    INV  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  inv_cnt_q, inv_cnt_d;
  logic [IDX_W-1:0]  acc_idx;
  logic              rd_vld_q;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q   <= IDLE;
      inv_cnt_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      inv_cnt_q <= inv_cnt_d;
      rd_vld_q  <= rd_gnt;
    end
  end

  always_comb begin
    state_d       = state_q;
    inv_cnt_d     = inv_cnt_q;
    rd_gnt        = 1'b0;
    wr_gnt        = 1'b0;
    jtlb_data_cen = 1'b0;
    jtlb_data_wen = 2'b00;
    acc_idx       = '0;
    jtlb_data_din = '0;
    case (state_q)
      IDLE: begin
        if (inv_all_req) begin
          state_d = INV;
        end else if (wr_req) begin
          // An empty way mask is granted but never touches the array.
          wr_gnt        = 1'b1;
          jtlb_data_cen = |wr_way;
          jtlb_data_wen = wr_way;
          acc_idx       = wr_idx;
          jtlb_data_din = {wr_data, wr_data};
        end else if (rd_req) begin
          rd_gnt        = 1'b1;
          jtlb_data_cen = 1'b1;
          acc_idx       = rd_idx;
        end
      end
      INV: begin
        jtlb_data_cen = 1'b1;
        jtlb_data_wen = 2'b11;
        acc_idx       = inv_cnt_q;
        if (inv_cnt_q == INV_LAST) begin
          inv_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          inv_cnt_d = inv_cnt_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Keep the array clock gate closed and refuse requests while reset is held.
    if (!cpurst_b) begin
      rd_gnt        = 1'b0;
      wr_gnt        = 1'b0;
      jtlb_data_cen = 1'b0;
      jtlb_data_wen = 2'b00;
    end
  end

  assign inv_busy      = (state_q == INV);
  assign jtlb_data_idx = {{(9-IDX_W){1'b0}}, acc_idx};

`ifdef AQ_MMU_JTLB_DATA_OUT_FLOP_EN
  logic                rd_vld_dly_q;
  logic [2*WAY_W-1:0]  dout_q;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_vld_dly_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      rd_vld_dly_q <= rd_vld_q;
      if (rd_vld_q) begin
        dout_q <= jtlb_data_dout;
      end
    end
  end

  assign rd_vld       = rd_vld_dly_q;
  assign rd_data_way1 = dout_q[2*WAY_W-1:WAY_W];
  assign rd_data_way0 = dout_q[WAY_W-1:0];
`else
  assign rd_vld       = rd_vld_q;
  assign rd_data_way1 = jtlb_data_dout[2*WAY_W-1:WAY_W];
  assign rd_data_way0 = jtlb_data_dout[WAY_W-1:0];
`endif

endmodule

// File: tb/tb_aq_mmu_jtlb_data_ctrl.sv
// Bench for aq_mmu_jtlb_data_ctrl: array model plus a transaction-level reference of expected contents.
module tb_aq_mmu_jtlb_data_ctrl;

`ifdef AQ_MMU_JTLB_DATA_OUT_FLOP_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_req = 1'b0, wr_req = 1'b0, inv_all_req = 1'b0;
  logic [5:0]  rd_idx = '0, wr_idx = '0;
  logic [1:0]  wr_way = '0;
  logic [43:0] wr_data = '0;
  logic        rd_gnt, wr_gnt, inv_busy, cen, rd_vld;
  logic [1:0]  wen;
  logic [8:0]  idx;
  logic [87:0] din;
  logic [43:0] way1, way0;

  logic [87:0] arr_mem [64] = '{default: '0};
  logic [87:0] arr_dout = '0;

  logic [87:0] ref_mem [64] = '{default: '0};
  int          inv_left = 0;
  typedef struct {
    bit          vld;
    logic [87:0] data;
  } rd_t;
  rd_t         rd_q[$];
  logic [87:0] last_data = '0;
  logic [87:0] obs_last = '0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  aq_mmu_jtlb_data_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .rd_req         (rd_req),
    .rd_idx         (rd_idx),
    .rd_gnt         (rd_gnt),
    .wr_req         (wr_req),
    .wr_idx         (wr_idx),
    .wr_way         (wr_way),
    .wr_data        (wr_data),
    .wr_gnt         (wr_gnt),
    .inv_all_req    (inv_all_req),
    .inv_busy       (inv_busy),
    .jtlb_data_cen  (cen),
    .jtlb_data_wen  (wen),
    .jtlb_data_idx  (idx),
    .jtlb_data_din  (din),
    .jtlb_data_dout (arr_dout),
    .rd_vld         (rd_vld),
    .rd_data_way1   (way1),
    .rd_data_way0   (way0)
  );

  // Single-port array: write per way mask, read data appears the next cycle.
  always @(posedge clk) begin
    if (cen) begin
      if (wen[0]) arr_mem[idx[5:0]][43:0]  <= din[43:0];
      if (wen[1]) arr_mem[idx[5:0]][87:44] <= din[87:44];
      if (wen == 2'b00) arr_dout <= arr_mem[idx[5:0]];
    end
  end

  task automatic check_eq(input string tag, input logic [87:0] got, input logic [87:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // One clock cycle: drive requests, check outputs against the reference, advance the reference.
  task automatic cycle(input bit rq, input logic [5:0] ri, input bit wq, input logic [5:0] wi,
                       input logic [1:0] wy, input logic [43:0] wd, input bit iq);
    bit          e_rg, e_wg, e_cen, start_inv;
    logic [1:0]  e_wen;
    logic [5:0]  e_idx;
    logic [87:0] e_din;
    rd_t         front;
    rd_req = rq; rd_idx = ri; wr_req = wq; wr_idx = wi; wr_way = wy; wr_data = wd;
    inv_all_req = iq;
    #3;
    e_rg = 0; e_wg = 0; e_cen = 0; start_inv = 0; e_wen = 2'b00; e_idx = '0; e_din = '0;
    if (inv_left > 0) begin
      e_cen = 1; e_wen = 2'b11; e_idx = 6'(64 - inv_left);
    end else if (iq) begin
      start_inv = 1;
    end else if (wq) begin
      e_wg = 1; e_cen = (wy != 2'b00); e_wen = wy; e_idx = wi; e_din = {wd, wd};
    end else if (rq) begin
      e_rg = 1; e_cen = 1; e_idx = ri;
    end
    check_eq("rd_gnt", 88'(rd_gnt), 88'(e_rg));
    check_eq("wr_gnt", 88'(wr_gnt), 88'(e_wg));
    check_eq("cen", 88'(cen), 88'(e_cen));
    check_eq("inv_busy", 88'(inv_busy), 88'(inv_left > 0));
    if (e_cen) begin
      check_eq("wen", 88'(wen), 88'(e_wen));
      check_eq("idx", 88'(idx), 88'({3'b000, e_idx}));
      if (e_wen != 2'b00) check_eq("din", din, e_din);
    end
    front.vld = 0; front.data = '0;
    if (rd_q.size() == LAT) front = rd_q.pop_front();
    check_eq("rd_vld", 88'(rd_vld), 88'(front.vld));
    if (front.vld) begin
      check_eq("rd_data", {way1, way0}, front.data);
      last_data = front.data;
    end else if (LAT == 2) begin
      check_eq("rd_hold", {way1, way0}, last_data);
    end
    if (rd_vld) obs_last = {way1, way0};
    rd_q.push_back('{vld: e_rg, data: ref_mem[e_idx]});
    if (e_cen) begin
      if (e_wen[0]) ref_mem[e_idx][43:0]  = e_din[43:0];
      if (e_wen[1]) ref_mem[e_idx][87:44] = e_din[87:44];
    end
    if (inv_left > 0) inv_left--;
    if (start_inv) inv_left = 64;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 6'd0, 0, 6'd0, 2'b00, 44'd0, 0);
  endtask

  initial begin
    int n_busy;
    // Reset: requests present but nothing granted.
    rd_req = 1; wr_req = 1; wr_way = 2'b11;
    #12;
    check_eq("rst_rd_gnt", 88'(rd_gnt), 88'(0));
    check_eq("rst_wr_gnt", 88'(wr_gnt), 88'(0));
    check_eq("rst_cen", 88'(cen), 88'(0));
    check_eq("rst_wen", 88'(wen), 88'(0));
    check_eq("rst_busy", 88'(inv_busy), 88'(0));
    check_eq("rst_vld", 88'(rd_vld), 88'(0));
    rst_n = 1;
    @(posedge clk); #1;

    // Write idx 5 way0, then read it back.
    cycle(0, 6'd0, 1, 6'd5, 2'b01, 44'h123, 0);
    cycle(1, 6'd5, 0, 6'd0, 2'b00, 44'd0, 0);
    idle(LAT);
    check_eq("tp_way0", 88'(obs_last[43:0]), 88'(44'h123));

    // Simultaneous write and read: write first, read the next cycle.
    cycle(1, 6'd7, 1, 6'd3, 2'b11, 44'hABC, 0);
    cycle(1, 6'd7, 0, 6'd0, 2'b00, 44'd0, 0);
    idle(LAT);

    // Empty way mask leaves contents untouched.
    cycle(0, 6'd0, 1, 6'd10, 2'b10, 44'h55, 0);
    cycle(0, 6'd0, 1, 6'd10, 2'b00, 44'hFFF, 0);
    cycle(1, 6'd10, 0, 6'd0, 2'b00, 44'd0, 0);
    idle(LAT);
    check_eq("nop_way1", 88'(obs_last[87:44]), 88'(44'h55));

    // Invalidate with a held read; second pulse at sweep cycle 30 is ignored.
    cycle(1, 6'd3, 0, 6'd0, 2'b00, 44'd0, 1);
    n_busy = 0;
    for (int k = 0; k < 64; k++) begin
      if (inv_busy) n_busy++;
      cycle(1, 6'd3, 0, 6'd0, 2'b00, 44'd0, k == 30);
    end
    check_eq("inv_len", 88'(n_busy), 88'(64));
    cycle(1, 6'd3, 0, 6'd0, 2'b00, 44'd0, 0);
    idle(LAT);
    check_eq("inv_zero", obs_last, 88'd0);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      cycle(1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom_range(0, 2) == 0), 6'($urandom),
            2'($urandom), 44'({$urandom, $urandom}), $urandom_range(0, 59) == 0);
    end
    while (inv_left > 0) idle(1);
    idle(LAT);

    // Reset in the middle of a sweep.
    cycle(0, 6'd0, 0, 6'd0, 2'b00, 44'd0, 1);
    idle(20);
    rd_req = 1; wr_req = 1; wr_way = 2'b11;
    #1 rst_n = 0;
    #1;
    check_eq("mid_rst_busy", 88'(inv_busy), 88'(0));
    check_eq("mid_rst_cen", 88'(cen), 88'(0));
    check_eq("mid_rst_wr_gnt", 88'(wr_gnt), 88'(0));
    @(posedge clk); #2;
    rst_n = 1;
    inv_left = 0;
    rd_q.delete();
    last_data = '0;
    @(posedge clk); #1;
    cycle(0, 6'd0, 0, 6'd0, 2'b00, 44'd0, 1);
    idle(64);
    for (int k = 0; k < 20; k++) cycle(1, 6'($urandom), 0, 6'd0, 2'b00, 44'd0, 0);
    idle(LAT);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aq_mmu_jtlb_data_ctrl.md
Name: aq_mmu_jtlb_data_ctrl

Overview:
- Access controller directly upstream of the JTLB data array. Arbitrates lookup reads, refill writes and an invalidate-all sweep onto the single-port array interface (cen/wen/idx/din).
- Consumes the array's 88-bit dout and returns it as two 44-bit per-way entries with a valid strobe.
- Sits between the MMU lookup/refill logic and the data array; the array's gated clock is enabled from this block's jtlb_data_cen.

Parameters:
- IDX_W, 6, array index width used; jtlb_data_idx upper bits tie to 0.
- ENTRY_NUM, 64, number of sets swept by invalidate-all.
- WAY_W, 44, data width per way.

Ports:
- forever_cpuclk  in  1  core clock; one clock domain.
- cpurst_b  in  1  asynchronous active-low reset.
- rd_req  in  1  lookup read request.
- rd_idx  in  6  read set index.
- rd_gnt  out  1  read accepted this cycle (combinational).
- wr_req  in  1  refill write request.
- wr_idx  in  6  write set index.
- wr_way  in  2  way write mask; bit1 = upper 44 bits, bit0 = lower.
- wr_data  in  44  entry data; replicated into both way halves of din.
- wr_gnt  out  1  write accepted this cycle (combinational).
- inv_all_req  in  1  single-cycle pulse; starts the invalidate-all sweep.
- inv_busy  out  1  sweep in progress.
- jtlb_data_cen  out  1  array access enable, active high.
- jtlb_data_wen  out  2  per-way write enable.
- jtlb_data_idx  out  9  array index; [8:6] = 0.
- jtlb_data_din  out  88  write data.
- jtlb_data_dout  in  88  array read data, valid the cycle after the read access.
- rd_vld  out  1  read data valid.
- rd_data_way1  out  44  dout[87:44].
- rd_data_way0  out  44  dout[43:0].

Behaviour:
- FSM states: IDLE and INV; 6-bit sweep counter inv_cnt.
- Reset values: state IDLE, inv_cnt 0, inv_busy 0, rd_vld 0. With cpurst_b low, cen, wen, rd_gnt and wr_gnt are all 0.
- IDLE priority, highest first: inv_all_req > wr_req > rd_req. Exactly one access per cycle.
- inv_all_req in IDLE:
  - Next state INV; inv_busy=1 from the next cycle.
  - No grant and no array access in the request cycle.
  - Same-cycle rd/wr requests are not granted; the requester must hold its request.
- Write grant (IDLE, no inv_all_req, wr_req=1):
  - wr_gnt=1, cen=1, wen=wr_way, idx=wr_idx, din={wr_data,wr_data}.
  - wr_way=2'b00: wr_gnt=1, cen=0; no-op.
- Read grant (IDLE, no inv/wr, rd_req=1):
  - rd_gnt=1, cen=1, wen=00, idx=rd_idx.
  - Read in cycle N: rd_vld=1 in cycle N+1 with rd_data = jtlb_data_dout.
  - Back-to-back reads give one rd_vld per cycle.
- Write then read of the same idx in the next cycle returns the newly written data; the array provides this, no forwarding logic.
- INV state:
  - Each cycle: cen=1, wen=11, idx=inv_cnt, din=0; inv_cnt increments.
  - At inv_cnt==ENTRY_NUM-1: that write completes, inv_cnt returns to 0, next state IDLE, inv_busy falls the following cycle.
  - Sweep takes exactly 64 cycles.
  - During INV: rd_gnt=wr_gnt=0; inv_all_req is ignored (not queued).
- A read granted the cycle before INV entry still returns rd_vld in the next cycle.
- Reset mid-sweep: immediate return to IDLE, inv_cnt=0. Partially cleared array contents are undefined to software, which must reissue the invalidate.
- rd_data_* hold the unregistered dout value when rd_vld=0; consumers must qualify with rd_vld.

Optional Feature:
- Macro: AQ_MMU_JTLB_DATA_OUT_FLOP_EN.
- Defined: dout is captured in an 88-bit register reset to 0; rd_vld moves to N+2 and rd_data_* come from the register, updated only when the delayed valid is set (held otherwise).
- Undefined: rd_vld at N+1, data passed straight through from dout, no data register.

Test Plan:
- Reset release, then wr_req idx=5, way=01, data=0x123 -> wr_gnt=1, cen=1, wen=01, idx=9'd5, din={0x123,0x123}; next cycle rd idx=5 -> rd_vld at N+1, way0=0x123.
- wr_req and rd_req in the same cycle (idx 3 and 7) -> cycle 1 wr_gnt=1, rd_gnt=0; cycle 2 rd_gnt=1; rd_vld in cycle 3.
- inv_all_req pulse with rd_req high:
  - No grants in the pulse cycle; inv_busy=1 for 64 cycles; idx steps 0..63 with wen=11, din=0.
  - rd_gnt asserts the cycle after inv_busy falls; read of any idx returns 0.
- Second inv_all_req at sweep cycle 30 -> ignored; sweep still ends after 64 total cycles.
- cpurst_b asserted at sweep cycle 20 -> inv_busy=0, cen=0 asynchronously; after release, IDLE and inv_cnt=0 (next sweep starts at idx 0).
- wr_way=00 -> wr_gnt=1, cen=0; a following read of that idx returns the prior contents unchanged. With AQ_MMU_JTLB_DATA_OUT_FLOP_EN defined: rd_vld at N+2, and rd_data is held while rd_vld=0.
